// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//
// Command/status handshake between a requester and the shift_sequencer.
// The datapath control lines (decoder/ALU selects and ALU flags) are not part
// of this bundle; they stay plain ports on the sequencer.
//
// Parameters:
//   SELECTIONDECO  register decoder select width
//   COUNTW         shift-count width
//
// Signals:
//   sStart   start request (requester -> sequencer)
//   sDir     0 = shift left, 1 = shift right
//   sSrc     source register index
//   sDst     destination register index (all-ones is illegal)
//   sCount   number of shifts
//   sBusy    sequencer busy (every state except IDLE)
//   sDone    one-cycle completion pulse
//   sErr     sticky error flag, cleared by the next accepted start
//
// Modports:
//   master   the requester side
//   slave    the sequencer side
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int SELECTIONDECO = 3,
  parameter int COUNTW        = 4
);

  logic                     sStart;
  logic                     sDir;
  logic [SELECTIONDECO-1:0] sSrc;
  logic [SELECTIONDECO-1:0] sDst;
  logic [COUNTW-1:0]        sCount;
  logic                     sBusy;
  logic                     sDone;
  logic                     sErr;

  modport master (
    output sStart, sDir, sSrc, sDst, sCount,
    input  sBusy, sDone, sErr
  );

  modport slave (
    input  sStart, sDir, sSrc, sDst, sCount,
    output sBusy, sDone, sErr
  );

endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Shift-multiply controller for the register-file/ALU datapath. On an
// accepted start it reads a source register, runs it through the ALU shifter
// (left = x2, right = /2) a run-time number of times, writing each partial
// result back into the destination register, and then pulses sDone. Only
// decoder and ALU select lines are driven; the datapath itself is untouched.
//
// State sequence:  IDLE -> LOAD -> (SHIFT -> WRITE)*n -> DONE -> IDLE
//                  IDLE -> LOAD -> WRITE -> DONE           (n = 0, copy)
//                  IDLE -> DONE                            (illegal dst)
//
// Ports:
//   clk        rising-edge clock
//   highRst    synchronous active-high reset
//   cmd        shift_sequencer_if.slave: sStart/sDir/sSrc/sDst/sCount in,
//              sBusy/sDone/sErr out
//   sCarry     ALU carry flag for the current ALU op
//   sOverflow  ALU overflow flag for the current ALU op
//   sSelDecoA  register read select A
//   sSelDecoB  register read select B (always 0)
//   sSelDecoC  register write select (all-ones = no write)
//   sSelAlu    ALU operation code
//
// Build option:
//   SHIFT_SEQ_OVF_ABORT_EN  when defined, a left-shift carry/overflow still
//   completes that iteration's WRITE and then finishes early (destination
//   keeps the partial result). When undefined, all iterations run and only
//   sErr records the event.
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int                      SELECTIONALU  = 3,
  parameter int                      SELECTIONDECO = 3,
  parameter int                      COUNTW        = 4,
  parameter logic [SELECTIONALU-1:0] ALU_PASS      = 3'b000,
  parameter logic [SELECTIONALU-1:0] ALU_SHL       = 3'b100,
  parameter logic [SELECTIONALU-1:0] ALU_SHR       = 3'b101
) (
  input  logic                     clk,
  input  logic                     highRst,
  shift_sequencer_if.slave         cmd,
  input  logic                     sCarry,
  input  logic                     sOverflow,
  output logic [SELECTIONDECO-1:0] sSelDecoA,
  output logic [SELECTIONDECO-1:0] sSelDecoB,
  output logic [SELECTIONDECO-1:0] sSelDecoC,
  output logic [SELECTIONALU-1:0]  sSelAlu
);

  // All-ones write select means "no register is written".
  localparam logic [SELECTIONDECO-1:0] DECO_NONE = '1;
  localparam logic [COUNTW-1:0]        CNT_ONE   = COUNTW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [SELECTIONDECO-1:0] src_q, src_d;
  logic [SELECTIONDECO-1:0] dst_q, dst_d;
  logic                     dir_q, dir_d;
  logic [COUNTW-1:0]        cnt_q, cnt_d;
  logic                     first_q, first_d;
  logic                     err_q, err_d;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
  // Set when the current iteration's shift raised an error; forces the
  // following WRITE to exit straight to DONE.
  logic                     abort_q, abort_d;
`endif

  // Combinational output values before they reach the ports.
  logic [SELECTIONDECO-1:0] sel_a;
  logic [SELECTIONDECO-1:0] sel_c;
  logic [SELECTIONALU-1:0]  sel_alu;
  logic                     busy;
  logic                     done;

  // The first shift reads the source; every later one re-reads the
  // destination, which holds the previous partial result.
  logic [SELECTIONDECO-1:0] shift_a;
  logic [SELECTIONALU-1:0]  shift_alu;
  logic                     copy_op;
  logic                     shift_err;
  logic                     more_shifts;

  assign shift_a   = first_q ? src_q : dst_q;
  assign shift_alu = dir_q ? ALU_SHR : ALU_SHL;
  // A zero count is a plain copy; in WRITE a shift job always has cnt_q >= 1
  // because the decrement only happens on leaving WRITE.
  assign copy_op   = (cnt_q == '0);
  // Only left shifts can lose bits, so flags are ignored on right shifts.
  assign shift_err = ~dir_q & (sCarry | sOverflow);
  // Remaining count after this WRITE's decrement is still non-zero.
  assign more_shifts = (cnt_q > CNT_ONE);

  // -------------------------------------------------------------------------
  // State and datapath-control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (highRst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      err_q   <= err_d;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    err_d   = err_q;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
    abort_d = abort_q;
`endif

    sel_a   = '0;
    sel_c   = DECO_NONE;
    sel_alu = ALU_PASS;
    busy    = 1'b1;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (cmd.sStart) begin
          src_d   = cmd.sSrc;
          dst_d   = cmd.sDst;
          dir_d   = cmd.sDir;
          cnt_d   = cmd.sCount;
          first_d = 1'b1;
          err_d   = 1'b0;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
          abort_d = 1'b0;
`endif
          // An all-ones destination would collide with "no write": refuse
          // the job and report it without touching the register file.
          if (cmd.sDst == DECO_NONE) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        sel_a   = src_q;
        state_d = copy_op ? ST_WRITE : ST_SHIFT;
      end

      ST_SHIFT: begin
        sel_a   = shift_a;
        sel_alu = shift_alu;
        // Flags belong to the ALU op presented in this cycle, so they are
        // captured on the SHIFT -> WRITE edge.
        if (shift_err) begin
          err_d = 1'b1;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
          abort_d = 1'b1;
`endif
        end
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        // Keep A/ALU identical to the previous cycle so the written value is
        // the result the ALU has been computing.
        if (copy_op) begin
          sel_a   = src_q;
          sel_alu = ALU_PASS;
        end else begin
          sel_a   = shift_a;
          sel_alu = shift_alu;
          cnt_d   = cnt_q - CNT_ONE;
        end
        sel_c   = dst_q;
        first_d = 1'b0;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
        if (more_shifts && !abort_q) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
`else
        if (more_shifts) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
`endif
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sSelDecoA = sel_a;
  assign sSelDecoB = '0;
  assign sSelDecoC = sel_c;
  assign sSelAlu   = sel_alu;

  assign cmd.sBusy = busy;
  assign cmd.sDone = done;
  assign cmd.sErr  = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Drives shift_sequencer against a small 8 x 8-bit register file and ALU
// model. Each job pushes hand-computed expectations into a queue; a separate
// monitor watches the select lines, accumulates what the job did and, on
// sDone, pops and compares.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam logic [2:0] PASS = 3'b000;
  localparam logic [2:0] SHL  = 3'b100;
  localparam logic [2:0] SHR  = 3'b101;
  localparam logic [2:0] NONE = 3'b111;

  logic       clk = 1'b0;
  logic       highRst;
  logic       sCarry;
  logic       sOverflow;
  logic [2:0] sSelDecoA;
  logic [2:0] sSelDecoB;
  logic [2:0] sSelDecoC;
  logic [2:0] sSelAlu;

  shift_sequencer_if #(.SELECTIONDECO(3), .COUNTW(4)) cmd_if ();

  shift_sequencer #(
    .SELECTIONALU (3),
    .SELECTIONDECO(3),
    .COUNTW       (4)
  ) dut (
    .clk      (clk),
    .highRst  (highRst),
    .cmd      (cmd_if),
    .sCarry   (sCarry),
    .sOverflow(sOverflow),
    .sSelDecoA(sSelDecoA),
    .sSelDecoB(sSelDecoB),
    .sSelDecoC(sSelDecoC),
    .sSelAlu  (sSelAlu)
  );

  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  logic [7:0] regs [0:7];
  logic [7:0] a_val;
  logic [7:0] alu_res;
  logic       preset_en = 1'b0;
  logic [2:0] preset_idx = '0;
  logic [7:0] preset_val = '0;
  logic       force_carry = 1'b0;  // inject carry on the 2nd shift of a job
  int         txn_writes = 0;

  always_comb begin
    a_val     = regs[sSelDecoA];
    alu_res   = a_val;
    sCarry    = 1'b0;
    sOverflow = 1'b0;
    if (sSelAlu == SHL) begin
      alu_res   = {a_val[6:0], 1'b0};
      sCarry    = a_val[7];
      sOverflow = a_val[7] ^ a_val[6];
    end else if (sSelAlu == SHR) begin
      alu_res = {1'b0, a_val[7:1]};
      sCarry  = a_val[0];
    end
    if (force_carry) begin
      sCarry    = (sSelAlu == SHL) && (txn_writes == 1);
      sOverflow = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (preset_en) regs[preset_idx] <= preset_val;
    else if (sSelDecoC != NONE) regs[sSelDecoC] <= alu_res;
    if (!cmd_if.sBusy) txn_writes <= 0;
    else if (sSelDecoC != NONE) txn_writes <= txn_writes + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string      name;
    int         busy;
    logic       err;
    logic       chk_val;
    logic [2:0] dst;
    logic [7:0] val;
    int         writes;
    logic [2:0] walu;
    int         a_first;
    int         a_last;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         m_busy, m_writes, m_badc, m_badb, m_afirst, m_alast;
  logic [2:0] m_walu;

  task automatic mon_clear();
    m_busy = 0; m_writes = 0; m_badc = 0; m_badb = 0;
    m_afirst = -1; m_alast = -1; m_walu = PASS;
  endtask

  initial begin
    exp_t e;
    mon_clear();
    forever begin
      @(negedge clk);
      if (highRst) begin
        mon_clear();
      end else if (cmd_if.sBusy) begin
        m_busy++;
        if (sSelDecoB != 3'd0) m_badb++;
        if (sSelDecoC != NONE) begin
          m_writes++;
          m_walu = sSelAlu;
          if (sb_q.size() > 0 && sSelDecoC != sb_q[0].dst) m_badc++;
        end else if (sSelAlu != PASS) begin
          if (m_afirst < 0) m_afirst = int'(sSelDecoA);
          m_alast = int'(sSelDecoA);
        end
        if (cmd_if.sDone) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got sDone=1 expected no job pending");
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_busy"},   m_busy, e.busy);
            chk({e.name, "_err"},    int'(cmd_if.sErr), int'(e.err));
            chk({e.name, "_writes"}, m_writes, e.writes);
            chk({e.name, "_badc"},   m_badc, 0);
            chk({e.name, "_selb"},   m_badb, 0);
            chk({e.name, "_afirst"}, m_afirst, e.a_first);
            chk({e.name, "_alast"},  m_alast, e.a_last);
            if (e.writes > 0) chk({e.name, "_walu"}, int'(m_walu), int'(e.walu));
            if (e.chk_val) chk({e.name, "_val"}, int'(regs[e.dst]), int'(e.val));
            $display("job %s: busy=%0d err=%0b writes=%0d R%0d=%0d", e.name,
                     m_busy, cmd_if.sErr, m_writes, e.dst, regs[e.dst]);
          end
          mon_clear();
        end
      end else if (cmd_if.sDone) begin
        checks++;
        errors++;
        $display("FAIL done_idle: got sDone=1 with sBusy=0 expected 0");
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All tasks start and end at 1 time unit after a rising edge.
  task automatic preset(input logic [2:0] idx, input logic [7:0] val);
    preset_en = 1'b1; preset_idx = idx; preset_val = val;
    @(posedge clk); #1;
    preset_en = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] src, input logic [2:0] dst,
                          input logic dir, input logic [3:0] cnt);
    cmd_if.sSrc = src; cmd_if.sDst = dst; cmd_if.sDir = dir; cmd_if.sCount = cnt;
    cmd_if.sStart = 1'b1;
    @(posedge clk); #1;
    cmd_if.sStart = 1'b0;
  endtask

  task automatic push_exp(input string name, input int busy, input logic err,
                          input logic chk_val, input logic [2:0] dst,
                          input logic [7:0] val, input int writes,
                          input logic [2:0] walu, input int a_first, input int a_last);
    exp_t e;
    e.name = name; e.busy = busy; e.err = err; e.chk_val = chk_val; e.dst = dst;
    e.val = val; e.writes = writes; e.walu = walu; e.a_first = a_first; e.a_last = a_last;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no sDone expected one within 200 cycles", name);
      sb_q.delete();
    end
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    highRst = 1'b1;
    cmd_if.sStart = 1'b0; cmd_if.sDir = 1'b0; cmd_if.sSrc = '0;
    cmd_if.sDst = '0; cmd_if.sCount = '0;
    repeat (3) @(posedge clk);
    #1 highRst = 1'b0;

    @(negedge clk);
    chk("rst_a",    int'(sSelDecoA), 0);
    chk("rst_b",    int'(sSelDecoB), 0);
    chk("rst_c",    int'(sSelDecoC), 7);
    chk("rst_alu",  int'(sSelAlu), int'(PASS));
    chk("rst_busy", int'(cmd_if.sBusy), 0);
    chk("rst_done", int'(cmd_if.sDone), 0);
    chk("rst_err",  int'(cmd_if.sErr), 0);
    @(posedge clk); #1;

    // x2 once: R6=5 -> R0=10
    preset(3'd6, 8'd5);
    push_exp("shl1", 4, 1'b0, 1'b1, 3'd0, 8'd10, 1, SHL, 6, 6);
    start_op(3'd6, 3'd0, 1'b0, 4'd1);
    wait_idle("shl1");

    // x8: R1=3 -> R2=24, later shifts re-read R2
    preset(3'd1, 8'd3);
    push_exp("shl3", 8, 1'b0, 1'b1, 3'd2, 8'd24, 3, SHL, 1, 2);
    start_op(3'd1, 3'd2, 1'b0, 4'd3);
    wait_idle("shl3");

    // /4 in place: R3=13 -> 3
    preset(3'd3, 8'd13);
    push_exp("shr2", 6, 1'b0, 1'b1, 3'd3, 8'd3, 2, SHR, 3, 3);
    start_op(3'd3, 3'd3, 1'b1, 4'd2);
    wait_idle("shr2");

    // copy: R4=0x5A -> R5
    preset(3'd4, 8'h5A);
    push_exp("copy", 3, 1'b0, 1'b1, 3'd5, 8'h5A, 1, PASS, -1, -1);
    start_op(3'd4, 3'd5, 1'b0, 4'd0);
    wait_idle("copy");

    // carry injected on the second left shift of R0=0xC0
    preset(3'd0, 8'hC0);
    force_carry = 1'b1;
`ifdef SHIFT_SEQ_OVF_ABORT_EN
    push_exp("ovf", 6, 1'b1, 1'b1, 3'd0, 8'h00, 2, SHL, 0, 0);
`else
    push_exp("ovf", 8, 1'b1, 1'b1, 3'd0, 8'h00, 3, SHL, 0, 0);
`endif
    start_op(3'd0, 3'd0, 1'b0, 4'd3);
    wait_idle("ovf");
    force_carry = 1'b0;

    // reset while in SHIFT: job abandoned, no write to R2
    preset(3'd1, 8'd3);
    preset(3'd2, 8'h55);
    start_op(3'd1, 3'd2, 1'b0, 4'd3);
    @(posedge clk); #1;
    chk("rst_mid_in_shift", int'(sSelAlu), int'(SHL));
    highRst = 1'b1;
    @(posedge clk); #1;
    highRst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", int'(cmd_if.sBusy), 0);
    chk("rst_mid_c",    int'(sSelDecoC), 7);
    chk("rst_mid_err",  int'(cmd_if.sErr), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_r2",   int'(regs[2]), 8'h55);
    chk("rst_mid_idle", int'(cmd_if.sBusy), 0);

    // illegal destination: one busy cycle, error, no write
    push_exp("baddst", 1, 1'b1, 1'b0, 3'd7, 8'd0, 0, PASS, -1, -1);
    start_op(3'd1, 3'd7, 1'b0, 4'd2);
    wait_idle("baddst");
    chk("err_sticky", int'(cmd_if.sErr), 1);

    // next start clears sErr; a start pulse while busy is ignored
    preset(3'd1, 8'd3);
    push_exp("rearm", 4, 1'b0, 1'b1, 3'd4, 8'd6, 1, SHL, 1, 1);
    start_op(3'd1, 3'd4, 1'b0, 4'd1);
    cmd_if.sSrc = 3'd0; cmd_if.sDst = 3'd6; cmd_if.sCount = 4'd0;
    cmd_if.sStart = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmd_if.sStart = 1'b0;
    wait_idle("rearm");
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_busy", int'(cmd_if.sBusy), 0);
    chk("ignored_r6",   int'(regs[6]), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
